// File: rtl/stream_checker.sv
// Checks an incrementing byte stream from a show-ahead FIFO.
// Optional random pacing stalls: define STREAM_CHECKER_PACE_EN.
module stream_checker #(
  parameter logic [7:0] START_VALUE    = 8'h00,
  parameter logic [7:0] STOP_VALUE     = 8'h0F,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       good,
  output logic       bad,
  output logic       timeout,
  output logic [3:0] err_count,
  output logic [7:0] first_bad_data,
  output logic [7:0] first_bad_expected
);

  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    expected;
  logic [SW-1:0] starve_cnt;
  logic          xfer;
  logic          mismatch;
  logic          last;
  logic          starve_hit;
  logic          stall_go;
  logic          stall_end;

  // Gate with reset so the FIFO never sees a dequeue while held.
  assign ready = reset_n && (state == S_RUN);

  assign xfer     = ready && enable;
  assign mismatch = xfer && (data_in != expected);
  assign last     = xfer && (expected == STOP_VALUE);

  assign starve_hit = (state == S_RUN) && !enable &&
    (starve_cnt == SW'(TIMEOUT_CYCLES - 1));

`ifdef STREAM_CHECKER_PACE_EN
  logic [7:0] lfsr;
  logic [2:0] stall_cnt;

  // Fibonacci LFSR, taps 8,6,5,4, free-running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Load stall length after a non-final word, then count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 3'd0;
    end else if (xfer && !last) begin
      stall_cnt <= lfsr[2:0];
    end else if (state == S_STALL) begin
      stall_cnt <= stall_cnt - 3'd1;
    end
  end

  assign stall_go  = xfer && !last && (lfsr[2:0] != 3'd0);
  assign stall_end = (stall_cnt == 3'd1);
`else
  assign stall_go  = 1'b0;
  assign stall_end = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (last || starve_hit) begin
          state_nx = S_DONE;
        end else if (stall_go) begin
          state_nx = S_STALL;
        end
      end
      S_STALL: begin
        if (stall_end) begin
          state_nx = S_RUN;
        end
      end
      S_DONE: state_nx = S_DONE;
      default: state_nx = S_RUN;
    endcase
  end

  // Expected word, starvation count and sticky status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expected           <= START_VALUE;
      starve_cnt         <= '0;
      good               <= 1'b0;
      bad                <= 1'b0;
      timeout            <= 1'b0;
      err_count          <= 4'h0;
      first_bad_data     <= 8'h00;
      first_bad_expected <= 8'h00;
    end else begin
      if (xfer) begin
        expected   <= expected + 8'd1;
        starve_cnt <= '0;
      end else if ((state == S_RUN) && !enable) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (mismatch) begin
        bad <= 1'b1;
        if (err_count != 4'hF) begin
          err_count <= err_count + 4'h1;
        end
        if (err_count == 4'h0) begin
          first_bad_data     <= data_in;
          first_bad_expected <= expected;
        end
      end
      if (last) begin
        good <= (err_count == 4'h0) && !mismatch;
      end
      if (starve_hit) begin
        timeout <= 1'b1;
        bad     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker.
// Builds with or without STREAM_CHECKER_PACE_EN.
module tb_stream_checker;

`ifdef STREAM_CHECKER_PACE_EN
  localparam bit PACE = 1'b1;
`else
  localparam bit PACE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       good;
  logic       bad;
  logic       timeout;
  logic [3:0] err_count;
  logic [7:0] first_bad_data;
  logic [7:0] first_bad_expected;

  stream_checker #(
    .START_VALUE   (8'h00),
    .STOP_VALUE    (8'h0F),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .data_in           (data_in),
    .ready             (ready),
    .good              (good),
    .bad               (bad),
    .timeout           (timeout),
    .err_count         (err_count),
    .first_bad_data    (first_bad_data),
    .first_bad_expected(first_bad_expected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       good;
    logic       bad;
    logic       tmo;
    logic       rdy;
    logic       chk_rdy;
    logic [3:0] err;
    logic [7:0] fbd;
    logic [7:0] fbe;
  } resp_t;

  resp_t sb[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    pend = 1'b0;
  resp_t mr;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one cycle after each transfer, pop and compare.
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        mr = sb.pop_front();
        chk("resp_good", 32'(good), 32'(mr.good));
        chk("resp_bad", 32'(bad), 32'(mr.bad));
        chk("resp_timeout", 32'(timeout), 32'(mr.tmo));
        chk("resp_err", 32'(err_count), 32'(mr.err));
        chk("resp_fbd", 32'(first_bad_data), 32'(mr.fbd));
        chk("resp_fbe", 32'(first_bad_expected), 32'(mr.fbe));
        if (mr.chk_rdy) begin
          chk("resp_ready", 32'(ready), 32'(mr.rdy));
        end
      end
    end
    pend = reset_n && ready && enable;
    if (good && bad) begin
      chk("good_and_bad", 32'd1, 32'd0);
    end
  end

  task automatic send(input logic [7:0] w, input resp_t r);
    int n;
    n = 0;
    data_in = w;
    enable = 1'b1;
    @(negedge clk);
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_wait", 32'd0, 32'd1);
    end else begin
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input logic [7:0] w[16], input int nw);
    logic [3:0] e;
    logic [7:0] fd;
    logic [7:0] fe;
    logic       b;
    logic       fin;
    resp_t      r;
    int         t0;
    e = 4'h0;
    fd = 8'h00;
    fe = 8'h00;
    b = 1'b0;
    t0 = 0;
    for (int i = 0; i < nw; i++) begin
      if (w[i] != 8'(i)) begin
        if (e == 4'h0) begin
          fd = w[i];
          fe = 8'(i);
        end
        b = 1'b1;
        if (e != 4'hF) e = e + 4'h1;
      end
      fin = (i == 15);
      r.good = fin && (e == 4'h0);
      r.bad = b;
      r.tmo = 1'b0;
      r.rdy = !fin;
      r.chk_rdy = fin || !PACE;
      r.err = e;
      r.fbd = fd;
      r.fbe = fe;
      send(w[i], r);
      if (i == 0) t0 = cyc;
      if (fin && !PACE) chk("consecutive", 32'(cyc - t0), 32'd15);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_good"}, 32'(good), 32'd0);
    chk({tag, "_bad"}, 32'(bad), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fbd"}, 32'(first_bad_data), 32'd0);
    chk({tag, "_fbe"}, 32'(first_bad_expected), 32'd0);
  endtask

  logic [7:0] words[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_zero("reset");
    do_reset();
    chk("ready_after_rst", 32'(ready), 32'd1);

    for (int i = 0; i < 16; i++) words[i] = 8'(i);
    run_stream(words, 16);
    repeat (3) @(posedge clk);
    #1;
    chk("clean_good_hold", 32'(good), 32'd1);
    chk("clean_ready_hold", 32'(ready), 32'd0);

    do_reset();
    words[5] = 8'h55;
    run_stream(words, 16);
    repeat (2) @(posedge clk);
    #1;
    chk("err_good_end", 32'(good), 32'd0);
    chk("err_fbd_end", 32'(first_bad_data), 32'h55);

    do_reset();
    for (int i = 0; i < 16; i++) words[i] = 8'hFF;
    run_stream(words, 16);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_err_hold", 32'(err_count), 32'hF);
    chk("sat_ready_hold", 32'(ready), 32'd0);

    do_reset();
    for (int i = 0; i < 16; i++) words[i] = 8'(i);
    run_stream(words, 3);
    enable = 1'b0;
    if (!PACE) begin
      repeat (7) @(posedge clk);
      #1;
      chk("tmo_early", 32'(timeout), 32'd0);
      chk("tmo_early_rdy", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
    end else begin
      for (int k = 0; k < 64 && !timeout; k++) begin
        @(posedge clk);
        #1;
      end
    end
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_bad", 32'(bad), 32'd1);
    chk("tmo_ready", 32'(ready), 32'd0);
    chk("tmo_good", 32'(good), 32'd0);

    do_reset();
    words[3] = 8'h33;
    run_stream(words, 8);
    enable = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_bad", 32'(bad), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_ready", 32'(ready), 32'd1);
    words[3] = 8'h03;
    run_stream(words, 16);
    repeat (2) @(posedge clk);
    #1;
    chk("restart_good", 32'(good), 32'd1);
    chk("restart_tmo", 32'(timeout), 32'd0);

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 SHALL have parameter START_VALUE, default 8'h00, first expected word.
REQ-002 SHALL have parameter STOP_VALUE, default 8'h0F, last expected word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max consecutive starved cycles while running.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  upstream FIFO holds data (driven from FIFO ~is_empty).
REQ-007 SHALL have port data_in  input  8  show-ahead FIFO head word.
REQ-008 SHALL have port ready  output  1  dequeue request to FIFO.
REQ-009 SHALL have port good  output  1  sticky; stream complete with zero errors.
REQ-010 SHALL have port bad  output  1  sticky; any mismatch or timeout.
REQ-011 SHALL have port timeout  output  1  sticky; starvation limit hit.
REQ-012 SHALL have port err_count  output  4  mismatch count, saturating.
REQ-013 SHALL have port first_bad_data  output  8  data_in at first mismatch.
REQ-014 SHALL have port first_bad_expected  output  8  expected value at first mismatch.

Function
REQ-015 SHALL implement states S_RUN, S_STALL, S_DONE; ready=1 only in S_RUN.
REQ-016 SHALL define a transfer as ready && enable high in the same cycle; data_in sampled that cycle, zero latency.
REQ-017 SHALL hold 8-bit expected register, starting START_VALUE, incremented modulo 256 on each transfer (wraps 8'hFF->8'h00 when STOP_VALUE < START_VALUE).
REQ-018 SHALL, on a transfer with data_in != expected, assert bad next cycle and increment err_count, saturating at 4'hF.
REQ-019 SHALL capture first_bad_data/first_bad_expected only on the first mismatch; later mismatches leave them unchanged.
REQ-020 SHALL, on a transfer with expected == STOP_VALUE, enter S_DONE next cycle; good asserts then iff err_count==0 and no mismatch on that final word.
REQ-021 SHALL, in S_DONE, hold ready=0 and all outputs frozen until reset.
REQ-022 SHALL count consecutive S_RUN cycles with enable=0; counter clears on any transfer; on reaching TIMEOUT_CYCLES assert timeout and bad and enter S_DONE, good remaining 0.
REQ-023 SHALL not advance the starvation counter in S_STALL.
REQ-024 SHALL never assert good and bad simultaneously.
REQ-025 SHALL, without pacing, never enter S_STALL.

Reset
REQ-026 SHALL on reset_n low, asynchronously: state S_RUN, expected=START_VALUE, good=0, bad=0, timeout=0, err_count=0, first_bad_*=0, starvation counter=0, pacing LFSR=8'hA5.
REQ-027 SHALL drive ready=0 while reset_n low; ready=1 first cycle after release.
REQ-028 SHALL abandon any in-progress stream on mid-operation reset; no partial state survives.

Configuration
REQ-029 SHALL compile pacing logic only when macro STREAM_CHECKER_PACE_EN is defined.
REQ-030 SHALL, with STREAM_CHECKER_PACE_EN: 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every non-reset cycle; after each non-final transfer load stall counter with lfsr[2:0]; if nonzero enter S_STALL, decrement each cycle, return to S_RUN on reaching 0.
REQ-031 SHALL, without STREAM_CHECKER_PACE_EN: no LFSR or stall counter; ready=1 in every S_RUN cycle.

Verification
REQ-032 SHALL cover: words 0x00..0x0F, enable always 1, no pacing -> 16 transfers on consecutive cycles, good=1 cycle after 0x0F, bad=0, err_count=0.
REQ-033 SHALL cover: stream with 0x05 replaced by 0x55 -> bad=1 cycle after that transfer, first_bad_data=0x55, first_bad_expected=0x05, err_count=1, good=0 at end.
REQ-034 SHALL cover: all 16 words set to 0xFF -> err_count saturates 4'hF, first_bad_data=0xFF, first_bad_expected=0x00, S_DONE after 16th transfer.
REQ-035 SHALL cover: enable held 0 after 3 transfers, TIMEOUT_CYCLES=8 -> timeout=1, bad=1, ready=0 exactly 8 cycles after last transfer.
REQ-036 SHALL cover: reset_n pulsed low mid-stream after word 0x07 -> all outputs zero immediately, restart expects START_VALUE.
REQ-037 SHALL cover: STREAM_CHECKER_PACE_EN defined -> ready deasserts for lfsr[2:0] cycles after transfers, stream still yields good=1, no timeout during stalls.
